// File: rtl/fft_pkg.sv
// Shared FFT helpers: index bit reversal used by the serial reorder buffer and the parallel bit_flip.
// Samples are carried as plain logic [M-1:0] vectors, with M a module parameter.
package fft_pkg;

  localparam int unsigned SAMPLE_W_DEFAULT = 8;

  // Reverses the low 'width' bits of idx; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned width);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = idx;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) begin
        r = {r[30:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One N x M reorder bank: writes land at the bit-reversed address, reads come from the natural address.
// The bank's full flag is set by the last write and cleared by the last read.
module reorder_bank
  import fft_pkg::*;
#(
  parameter int N     = 4,
  parameter int M     = 8,
  parameter int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [LOG2N-1:0] wr_cnt_i,
  input  logic [M-1:0]     wr_data_i,
  input  logic [LOG2N-1:0] rd_cnt_i,
  input  logic             set_full_i,
  input  logic             clr_full_i,
  output logic             full_o,
  output logic [M-1:0]     rd_data_o
);

  logic [M-1:0]     mem_q [N];
  logic [LOG2N-1:0] wr_addr;
  logic             full_q;
  logic             full_d;

  always_comb begin
    wr_addr = LOG2N'(bitrev(32'(wr_cnt_i), LOG2N));
    full_d  = full_q;
    // Set and clear never coincide: set needs an empty bank, clear a full one.
    if (set_full_i) begin
      full_d = 1'b1;
    end else if (clr_full_i) begin
      full_d = 1'b0;
    end
  end

  // Contents are deliberately left uninitialised; they are unobservable until rewritten.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  assign full_o    = full_q;
  assign rd_data_o = mem_q[rd_cnt_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Streaming bit-reversal reorder: bit-reversed arrival order in, natural order out,
// ping-ponging between two banks to sustain one sample per cycle.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = 4,
  parameter int M     = 8,
  parameter int LOG2N = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [M-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // ready and valid depend only on registered state, and held data stays stable until taken.

  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic [1:0]       full;
  logic [M-1:0]     rd_data [2];
  logic             accept;
  logic             rd_fire;
  logic             wlast;
  logic             rlast;

  always_comb begin
    in_ready  = !full[wbank_q];
    out_valid = full[rbank_q];
    accept    = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
    wlast     = (wcnt_q == LOG2N'(N - 1));
    rlast     = (rcnt_q == LOG2N'(N - 1));
    wcnt_d    = accept  ? wcnt_q + LOG2N'(1) : wcnt_q;
    rcnt_d    = rd_fire ? rcnt_q + LOG2N'(1) : rcnt_q;
    wbank_d   = wbank_q ^ (accept && wlast);
    rbank_d   = rbank_q ^ (rd_fire && rlast);
    out_data  = out_valid ? rd_data[rbank_q] : '0;
    out_last  = out_valid && rlast;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(
      .N    (N),
      .M    (M),
      .LOG2N(LOG2N)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (accept && (wbank_q == 1'(b))),
      .wr_cnt_i  (wcnt_q),
      .wr_data_i (in_data),
      .rd_cnt_i  (rcnt_q),
      .set_full_i(accept && wlast && (wbank_q == 1'(b))),
      .clr_full_i(rd_fire && rlast && (rbank_q == 1'(b))),
      .full_o    (full[b]),
      .rd_data_o (rd_data[b])
    );
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: an N=4 and an N=8 instance checked every cycle against a frame-level model.
module tb_fft_bitrev_reorder;

  localparam int M = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        in_valid_v, in_ready_v, out_valid_v, out_ready_v, out_last_v;
  logic [1:0][M-1:0] in_data_v, out_data_v;

  fft_bitrev_reorder #(.N(4), .M(M)) dut4 (
    .clk(clk), .rst(rst),
    .in_data(in_data_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .out_data(out_data_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_last(out_last_v[0])
  );

  fft_bitrev_reorder #(.N(8), .M(M)) dut8 (
    .clk(clk), .rst(rst),
    .in_data(in_data_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .out_data(out_data_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_last(out_last_v[1])
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  bit ref_live = 0;

  int         nfull [2];
  int         wpos  [2];
  int         rpos  [2];
  logic [M-1:0] fbuf [2][8];
  logic [M-1:0] exp_q0[$];
  logic [M-1:0] exp_q1[$];
  int         got_q0[$];
  int         got_q1[$];
  bit         rdy_low_seen [2];

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int ref_bitrev(input int idx, input int n);
    int r = 0;
    for (int w = n; w > 1; w = w / 2) begin
      r = r * 2 + idx % 2;
      idx = idx / 2;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", name, n_of(d), act, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] exp_front(input int d);
    if (d == 0) return (exp_q0.size() > 0) ? exp_q0[0] : '0;
    return (exp_q1.size() > 0) ? exp_q1[0] : '0;
  endfunction

  task automatic exp_push(input int d, input logic [M-1:0] v);
    if (d == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endtask

  task automatic exp_pop(input int d);
    if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
  endtask

  task automatic got_push(input int d, input int v);
    if (d == 0) got_q0.push_back(v); else got_q1.push_back(v);
  endtask

  // Outputs are compared at the falling edge; the same sample of the inputs advances the model.
  always @(negedge clk) begin
    if (rst) begin
      ref_live = 1;
      for (int d = 0; d < 2; d++) begin
        nfull[d] = 0; wpos[d] = 0; rpos[d] = 0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else if (ref_live) begin
      for (int d = 0; d < 2; d++) begin
        int  n;
        bit  acc;
        bit  fire;
        n = n_of(d);
        chk("in_ready", d, int'(in_ready_v[d]), int'(nfull[d] < 2));
        chk("out_valid", d, int'(out_valid_v[d]), int'(nfull[d] > 0));
        if (nfull[d] > 0) begin
          chk("out_data", d, int'(out_data_v[d]), int'(exp_front(d)));
          chk("out_last", d, int'(out_last_v[d]), int'(rpos[d] == n - 1));
        end else begin
          chk("idle_data", d, int'(out_data_v[d]), 0);
          chk("idle_last", d, int'(out_last_v[d]), 0);
        end
        if (!in_ready_v[d]) rdy_low_seen[d] = 1;
        acc  = in_valid_v[d] && (nfull[d] < 2);
        fire = (nfull[d] > 0) && out_ready_v[d];
        if (fire) begin
          got_push(d, int'(out_data_v[d]) + (out_last_v[d] ? 256 : 0));
          exp_pop(d);
          rpos[d]++;
          if (rpos[d] == n) begin
            rpos[d] = 0;
            nfull[d]--;
          end
        end
        if (acc) begin
          fbuf[d][wpos[d]] = in_data_v[d];
          wpos[d]++;
          if (wpos[d] == n) begin
            for (int k = 0; k < n; k++) exp_push(d, fbuf[d][ref_bitrev(k, n)]);
            wpos[d] = 0;
            nfull[d]++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) tick();
    rst = 1'b0;
  endtask

  task automatic send(input int d, input logic [M-1:0] v);
    bit ok;
    ok = 0;
    in_data_v[d[0]]  = v;
    in_valid_v[d[0]] = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = in_ready_v[d[0]];
      tick();
    end
    if (!ok) chk("send_timeout", d, 0, 1);
  endtask

  task automatic idle(input int d);
    in_valid_v[d[0]] = 1'b0;
    in_data_v[d[0]]  = M'($urandom);
  endtask

  task automatic wait_drain(input int d);
    int i;
    for (i = 0; i < 400 && nfull[d] != 0; i++) tick();
    if (nfull[d] != 0) chk("drain_timeout", d, nfull[d], 0);
  endtask

  task automatic clear_got();
    got_q0.delete();
    got_q1.delete();
  endtask

  // Entries carry data in bits 7:0 and out_last as +256.
  task automatic check_got(input int d, input string name, input int e[8], input int cnt);
    int sz;
    sz = (d == 0) ? got_q0.size() : got_q1.size();
    chk({name, "_count"}, d, sz, cnt);
    for (int i = 0; i < cnt && i < sz; i++)
      chk(name, d, (d == 0) ? got_q0[i] : got_q1[i], e[i]);
    clear_got();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e [8];
    int accepted;
    logic [M-1:0] nxt;
    bit rdy;
    bit done;
    int i;

    rst = 1'b1;
    in_valid_v = '0;
    out_ready_v = '0;
    in_data_v = '0;
    tick();
    do_reset(2);

    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", d, int'(in_ready_v[d]), 1);
      chk("rst_out_valid", d, int'(out_valid_v[d]), 0);
      chk("rst_out_data", d, int'(out_data_v[d]), 0);
      chk("rst_out_last", d, int'(out_last_v[d]), 0);
    end

    // single frame
    out_ready_v[0] = 1'b1;
    send(0, 8'd1); send(0, 8'd2); send(0, 8'd3);
    chk("pre_last_valid", 0, int'(out_valid_v[0]), 0);
    send(0, 8'd4);
    chk("latency_valid", 0, int'(out_valid_v[0]), 1);
    chk("latency_data", 0, int'(out_data_v[0]), 1);
    idle(0);
    wait_drain(0);
    e = '{1, 3, 2, 4 + 256, 0, 0, 0, 0};
    check_got(0, "single", e, 4);

    // back-to-back frames
    rdy_low_seen[0] = 0;
    for (int v = 1; v <= 8; v++) send(0, M'(v));
    idle(0);
    wait_drain(0);
    e = '{1, 3, 2, 4 + 256, 5, 7, 6, 8 + 256};
    check_got(0, "b2b", e, 8);
    chk("b2b_ready_low", 0, int'(rdy_low_seen[0]), 0);

    // backpressure
    out_ready_v[0] = 1'b0;
    accepted = 0;
    nxt = 8'd1;
    for (int c = 0; c < 12; c++) begin
      in_valid_v[0] = 1'b1;
      in_data_v[0]  = nxt;
      rdy = in_ready_v[0];
      tick();
      if (rdy) begin
        nxt++;
        accepted++;
      end
    end
    idle(0);
    chk("bp_accepted", 0, accepted, 8);
    chk("bp_ready_low", 0, int'(in_ready_v[0]), 0);
    out_ready_v[0] = 1'b1;
    for (i = 1; i <= 20; i++) begin
      tick();
      if (in_ready_v[0]) break;
    end
    chk("bp_ready_return", 0, i, 4);
    wait_drain(0);
    e = '{1, 3, 2, 4 + 256, 5, 7, 6, 8 + 256};
    check_got(0, "bp", e, 8);

    // reset mid-frame
    send(0, 8'd21); send(0, 8'd22);
    idle(0);
    do_reset(1);
    for (int v = 9; v <= 12; v++) send(0, M'(v));
    idle(0);
    wait_drain(0);
    e = '{9, 11, 10, 12 + 256, 0, 0, 0, 0};
    check_got(0, "midrst", e, 4);

    // N=8 natural reorder
    out_ready_v[1] = 1'b1;
    for (int v = 0; v < 8; v++) send(1, M'(v));
    idle(1);
    wait_drain(1);
    e = '{0, 4, 2, 6, 1, 5, 3, 7 + 256};
    check_got(1, "n8", e, 8);

    // N=8 with random out_ready
    done = 0;
    fork
      begin
        for (int v = 0; v < 8; v++) send(1, M'(v));
        idle(1);
        done = 1;
      end
      begin
        while (!done) begin
          out_ready_v[1] = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    out_ready_v[1] = 1'b1;
    wait_drain(1);
    e = '{0, 4, 2, 6, 1, 5, 3, 7 + 256};
    check_got(1, "n8_rand", e, 8);

    // random frames, random gaps, random backpressure on both sizes
    for (int d = 0; d < 2; d++) begin
      done = 0;
      fork
        begin
          for (int k = 0; k < 6 * n_of(d); k++) begin
            send(d, M'($urandom));
            if ($urandom_range(0, 3) == 0) begin
              idle(d);
              repeat ($urandom_range(1, 3)) tick();
            end
          end
          idle(d);
          done = 1;
        end
        begin
          while (!done) begin
            out_ready_v[d[0]] = 1'($urandom_range(0, 3) != 0);
            tick();
          end
        end
      join
      out_ready_v[d[0]] = 1'b1;
      wait_drain(d);
    end
    clear_got();

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Streaming bit-reversal reorder buffer for the FFT datapath. It accepts samples in bit-reversed index order, which is how the radix-2 FFT core emits them, and delivers them in natural index order. The static `bit_flip` permutation handles the reverse mapping on parallel vectors. This block performs the same permutation on a serial valid/ready stream, using ping-pong banks to sustain one sample per cycle.

## Interface
- `N`, default 4: samples per frame. Power of two, ≥ 2.
- `M`, default 8: sample width in bits.
- `LOG2N`, default `$clog2(N)`: index width. Derived; do not override.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  M  input sample. Arrival position p within the frame carries natural index bitrev(p).
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `out_data`  out  M  output sample in natural order. Driven 0 when `out_valid` = 0.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the sample this cycle.
- `out_last`  out  1  high together with `out_valid` on natural index N-1 of each frame.

## Operation
- Storage: two banks of N×M flops. Per-bank `full` flag. Write pointer `wbank`, read pointer `rbank`. Counters `wcnt` and `rcnt`, each LOG2N bits.
- Write side:
  - `in_ready` = !full[wbank].
  - Accept occurs when `in_valid` && `in_ready`.
  - On accept: `mem[wbank][bitrev(wcnt)]` ← `in_data`, then `wcnt`++.
  - On accept with `wcnt` = N-1: set full[wbank], toggle `wbank`, wrap `wcnt` to 0.
- Read side:
  - `out_valid` = full[rbank].
  - `out_data` = `mem[rbank][rcnt]` when valid, else 0.
  - `out_last` = `out_valid` && (`rcnt` == N-1).
  - On handshake (`out_valid` && `out_ready`): `rcnt`++.
  - On handshake with `rcnt` = N-1: clear full[rbank], toggle `rbank`, wrap `rcnt` to 0.
- Bank states, per bank: FILLING (!full, is `wbank`) → FULL (full set on last write) → DRAINING (full, is `rbank`) → FILLING (full cleared on last read).
- Simultaneous events:
  - Last write to one bank and last read from the other bank in the same cycle are legal; both take effect.
  - Set and clear of the same bank in one cycle cannot occur, because set requires !full and clear requires full.
- Both banks full: `in_ready` = 0. No sample is ever dropped or overwritten.
- `in_data` is ignored when no accept occurs.
- `bitrev`: reverses the LOG2N-bit index. N = 4: 0→0, 1→2, 2→1, 3→3.
- Reset state:
  - full = 00, `wbank` = `rbank` = 0, `wcnt` = `rcnt` = 0.
  - Outputs: `out_valid` = 0, `out_data` = 0, `out_last` = 0, `in_ready` = 1.
  - Bank contents are not cleared. They are unobservable until rewritten.
- Reset mid-frame discards any partial frame and all full banks. The first accept after reset is position 0.

## Timing
- Write: 1 accept per cycle maximum. Registered on the rising edge.
- Latency: if the last sample of a frame is accepted at edge k, `out_valid` is high in the cycle following edge k. Natural index 0 is presented in that cycle.
- Throughput: with `out_ready` held at 1 and back-to-back frames, `in_ready` stays 1 and output runs at 1 sample per cycle after the first frame fills.
- Capacity: at most 2N samples can be buffered while `out_ready` = 0.
- `out_valid` and `in_ready` are functions of registered state only. There is no combinational path from `in_valid` or `out_ready`.
- `out_data` and `out_last` hold stable while `out_valid` && !`out_ready`.

## Structure
- Shared package `fft_pkg` holds:
  - `function bitrev(idx, width)`, shared with `bit_flip`.
  - The sample type `logic [M-1:0]` convention.
- Sub-module `reorder_bank`: one N×M bank with a write port at a bit-reversed address, a read port at a natural address, and its `full` flag with set/clear inputs.
- The top level instantiates two `reorder_bank`s plus the pointers and counters. Target size is roughly 150–250 lines total.

## Test plan
- Reset defaults: assert `rst` for 2 cycles → `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_last` = 0.
- Single frame, N=4, M=8, `out_ready` = 1: send 1, 2, 3, 4 → outputs 1, 3, 2, 4. `out_valid` rises the cycle after the 4 is accepted. `out_last` is high only with 4.
- Back-to-back frames with `in_valid` and `out_ready` held at 1: send 1–8 → outputs 1, 3, 2, 4, 5, 7, 6, 8 on consecutive cycles. `in_ready` is never 0. `out_last` is high with 4 and with 8.
- Backpressure: `out_ready` = 0 while offering 12 samples → exactly 8 accepted and `in_ready` = 0 after the 8th. Then raise `out_ready` → outputs 1, 3, 2, 4, 5, 7, 6, 8, and `in_ready` returns to 1 the cycle after 4 is read.
- Reset mid-operation: accept 2 samples, assert `rst` for 1 cycle, then send 9, 10, 11, 12 → outputs 9, 11, 10, 12 only.
- N=8: send 0–7 → outputs 0, 4, 2, 6, 1, 5, 3, 7. With random `out_ready` toggling, output order and values are unchanged.
